// File: rtl/out_bram_ctrl.sv
// -----------------------------------------------------------------------------
// out_bram_ctrl
//
// Collects a job of 256-bit result beats into an external BRAM, then streams
// the stored data back out as 128-bit words.
//
// Job flow:
//   IDLE  : waits for start and samples len, the job length in 256-bit beats.
//   FILL  : accepts len beats. Each accepted beat is written at an even BRAM
//           address in the same cycle. The BRAM splits it into two 128-bit
//           words.
//   DRAIN : reads BRAM words 0 .. 2*len-1 in ascending order. The data comes
//           back through a 2-entry skid buffer to the out_vld/out_rdy stream.
//   DONE  : pulses done for one cycle, then returns to IDLE.
//   A start with len == 0 goes straight from IDLE to DONE.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, len             job start pulse and beat count (sampled in IDLE)
//   in_vld/in_rdy/in_data  result-beat handshake (accepted only in FILL)
//   bram_we/_wr_addr/_wr_data  BRAM write port (address always even)
//   bram_re/_rd_addr/_rd_data  BRAM read port (1-cycle read latency)
//   out_vld/out_rdy/out_data   drain-stream handshake
//   busy                   high in any state other than IDLE
//   done                   one-cycle pulse at job end
//   err                    sticky length error
//
// Build option:
//   OUT_BRAM_CTRL_LEN_CHK_EN  When defined, a start with len > DEPTH/2 sets
//                             err (sticky until reset) and clamps the job to
//                             DEPTH/2 beats. When undefined, err is tied to 0
//                             and len is used as given.
// -----------------------------------------------------------------------------
module out_bram_ctrl #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DEPTH          = 2048,
  parameter int IN_DATA_WIDTH  = 256,
  parameter int OUT_DATA_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     len,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [IN_DATA_WIDTH-1:0]  in_data,
  output logic                      bram_we,
  output logic [ADDR_WIDTH-1:0]     bram_wr_addr,
  output logic [IN_DATA_WIDTH-1:0]  bram_wr_data,
  output logic                      bram_re,
  output logic [ADDR_WIDTH-1:0]     bram_rd_addr,
  input  logic [OUT_DATA_WIDTH-1:0] bram_rd_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  // Pointers and counters carry one extra bit. A job of DEPTH/2 beats can
  // then count all DEPTH words without wrapping back to zero.
  localparam int PTR_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     len_q;     // latched job length in beats
  logic [PTR_W-1:0]          wptr;      // next write address, steps by 2
  logic [PTR_W-1:0]          rptr;      // next read address, steps by 1
  logic [PTR_W-1:0]          ocnt;      // words handed out on the stream
  logic                      inflight;  // a read was issued last cycle

  // The skid buffer is 2 entries deep: a FIFO with head and tail pointers
  // plus an occupancy count.
  logic [OUT_DATA_WIDTH-1:0] skid [2];
  logic                      head;
  logic                      tail;
  logic [1:0]                count;

  logic [PTR_W-1:0]          words_total;
  logic [ADDR_WIDTH-1:0]     len_eff;
  logic                      beat_acc;
  logic                      last_beat;
  logic                      pop;
  logic                      last_word;
  logic                      rd_more;
  logic [1:0]                occ;

  // ---------------------------------------------------------------------------
  // Length handling
  // ---------------------------------------------------------------------------
`ifdef OUT_BRAM_CTRL_LEN_CHK_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(DEPTH / 2);

  logic len_over;
  logic err_q;

  assign len_over = (len > MAX_LEN);
  assign len_eff  = len_over ? MAX_LEN : len;
  assign err      = err_q;
`else
  assign len_eff  = len;
  assign err      = 1'b0;
`endif

  // Each beat holds two words, so a job is 2*len words long.
  assign words_total = {len_q, 1'b0};

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  // in_rdy is a register that is high exactly while in FILL. The write
  // strobe follows the handshake in the same cycle. The write address and
  // data buses are held at zero whenever no write is happening.
  assign beat_acc     = in_rdy & in_vld;
  assign last_beat    = beat_acc && ((wptr + PTR_W'(2)) == words_total);
  assign bram_we      = beat_acc;
  assign bram_wr_addr = beat_acc ? wptr[ADDR_WIDTH-1:0] : '0;
  assign bram_wr_data = beat_acc ? in_data : '0;

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  assign out_vld   = (count != 2'd0);
  assign out_data  = out_vld ? skid[head] : '0;
  assign pop       = out_vld & out_rdy;
  assign last_word = pop && (ocnt == (words_total - PTR_W'(1)));
  assign rd_more   = (rptr != words_total);

  // occ counts the words that will occupy the skid buffer after this edge:
  // words already held, plus the read in flight, minus the word leaving
  // now. Issuing a read only while occ < 2 means the buffer never
  // overflows. Counting the word leaving in this cycle lets the block
  // deliver one word per cycle while out_rdy stays high.
  assign occ          = count + {1'b0, inflight} - {1'b0, pop};
  assign bram_re      = (state == S_DRAIN) && rd_more && (occ < 2'd2);
  assign bram_rd_addr = bram_re ? rptr[ADDR_WIDTH-1:0] : '0;

  // ---------------------------------------------------------------------------
  // FSM, pointers and skid buffer
  // ---------------------------------------------------------------------------
  // NOTE: all state in this block uses non-blocking (<=) assignments. Every
  //       right-hand side then sees the value from before the edge, which
  //       the pointer and count updates below depend on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_q    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      ocnt     <= '0;
      inflight <= 1'b0;
      // NOTE: the skid entries are storage, but they drive out_data. They
      //       are cleared here so that every output reads 0 after reset.
      skid[0]  <= '0;
      skid[1]  <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      in_rdy   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef OUT_BRAM_CTRL_LEN_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      inflight <= bram_re;

      // Read data returns one cycle after bram_re. It is pushed into the
      // skid buffer on the cycle it arrives.
      if (inflight) begin
        skid[tail] <= bram_rd_data;
        tail       <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        ocnt <= ocnt + PTR_W'(1);
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};

      if (beat_acc) wptr <= wptr + PTR_W'(2);
      if (bram_re)  rptr <= rptr + PTR_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef OUT_BRAM_CTRL_LEN_CHK_EN
            if (len_over) err_q <= 1'b1;
`endif
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              len_q  <= len_eff;
              wptr   <= '0;
              rptr   <= '0;
              ocnt   <= '0;
              in_rdy <= 1'b1;
              state  <= S_FILL;
            end
          end
        end

        S_FILL: begin
          // in_rdy drops together with the move to DRAIN. No beat can be
          // accepted in the cycle after the last one.
          if (last_beat) begin
            in_rdy <= 1'b0;
            state  <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (last_word) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_bram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_out_bram_ctrl
//
// Self-checking bench for out_bram_ctrl.
//
// The bench contains a simple BRAM model. A 256-bit write at an even address
// stores its low half at that address and its high half at the next one.
// Reads return data one cycle later, and return zero when bram_re is low.
//
// For each job, the expected results come from the job description alone:
//   - writes at 0, 2, 4, ...
//   - reads at 0 .. 2*len-1
//   - the output stream: every beat, low half first, then high half
//   - one done pulse
//   - the latency and throughput figures
// A per-cycle monitor checks stall stability and read-issue occupancy.
// -----------------------------------------------------------------------------
module tb_out_bram_ctrl;

  localparam int AW    = 11;
  localparam int DEPTH = 2048;
  localparam int IW    = 256;
  localparam int OW    = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] len;
  logic          in_vld;
  logic          in_rdy;
  logic [IW-1:0] in_data;
  logic          bram_we;
  logic [AW-1:0] bram_wr_addr;
  logic [IW-1:0] bram_wr_data;
  logic          bram_re;
  logic [AW-1:0] bram_rd_addr;
  logic [OW-1:0] bram_rd_data;
  logic          out_vld;
  logic          out_rdy;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  out_bram_ctrl #(
    .ADDR_WIDTH    (AW),
    .DEPTH         (DEPTH),
    .IN_DATA_WIDTH (IW),
    .OUT_DATA_WIDTH(OW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_data     (in_data),
    .bram_we     (bram_we),
    .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data),
    .bram_re     (bram_re),
    .bram_rd_addr(bram_rd_addr),
    .bram_rd_data(bram_rd_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // BRAM model: 128-bit words, 256-bit writes to even addresses.
  logic [OW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (bram_we) begin
      mem[bram_wr_addr]     <= bram_wr_data[OW-1:0];
      mem[bram_wr_addr + 1] <= bram_wr_data[IW-1:OW];
    end
    bram_rd_data <= bram_re ? mem[bram_rd_addr] : '0;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor state
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            n_we, n_re, n_pop, n_done, busy_cycles, exp_beats;
  int            last_beat_cyc, first_vld_cyc, last_pop_cyc, done_cyc;
  bit            prev_stall, prev_last_beat, acc_last;
  bit            err_exp = 1'b0;
  logic [OW-1:0] prev_data;
  logic [AW-1:0] wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [OW-1:0] out_q[$];

  task automatic clear_mon();
    n_we = 0; n_re = 0; n_pop = 0; n_done = 0; busy_cycles = 0;
    last_beat_cyc = -1; first_vld_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_last_beat = 1'b0; acc_last = 1'b0;
    wr_q.delete(); rd_q.delete(); out_q.delete();
  endtask

  // Runs once per cycle, mid-cycle, after inputs and outputs have settled.
  task automatic sample();
    bit pop_now;
    pop_now = out_vld & out_rdy;
    if (prev_stall) begin
      check("stall_vld_held", out_vld, 1);
      check("stall_data_held", out_data, prev_data);
    end
    if (prev_last_beat) check("in_rdy_after_fill", in_rdy, 0);
    prev_last_beat = 1'b0;
    acc_last = in_vld & in_rdy;
    if (bram_we) begin
      wr_q.push_back(bram_wr_addr);
      n_we++;
      if (n_we == exp_beats) begin
        last_beat_cyc  = cyc;
        prev_last_beat = 1'b1;
      end
    end
    if (bram_re) begin
      // Words issued but not yet handed out, including this cycle's hand-off.
      check("re_pending_lt2", ((n_re - n_pop - int'(pop_now)) < 2), 1);
      rd_q.push_back(bram_rd_addr);
      n_re++;
    end
    if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (pop_now) begin
      out_q.push_back(out_data);
      n_pop++;
      last_pop_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) busy_cycles++;
    prev_stall = out_vld & ~out_rdy;
    prev_data  = out_data;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic zero_cycle(input string tag);
    @(negedge clk);
    check({tag, "_ctrl"}, {in_rdy, bram_we, bram_re, out_vld, busy, done, err}, 0);
    check({tag, "_addr"}, {bram_wr_addr, bram_rd_addr}, 0);
    check({tag, "_wr_data"}, bram_wr_data, 0);
    check({tag, "_out_data"}, out_data, 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [IW-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // rdy_mode: 0 = out_rdy held high, 1 = pattern 1,0,0,1, 2 = random.
  task automatic run_job(input int jlen, input int rdy_mode, input bit chk_data,
                         input bit poke_start, input int vld_pct);
    logic [IW-1:0] beats[$];
    logic [OW-1:0] exp_w;
    int eff, idx, start_cyc, bad;
    eff = jlen;
`ifdef OUT_BRAM_CTRL_LEN_CHK_EN
    if (eff > DEPTH / 2) begin
      eff     = DEPTH / 2;
      err_exp = 1'b1;
    end
`endif
    for (int i = 0; i < eff; i++) beats.push_back(rand_beat());
    clear_mon();
    exp_beats = eff;
    start     = 1'b1;
    len       = AW'(jlen);
    in_vld    = 1'b0;
    out_rdy   = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    idx   = 0;
    for (int c = 0; c < 20000 && n_done == 0; c++) begin
      if (acc_last) idx++;
      if (idx < eff) begin
        in_vld  = ($urandom_range(99) < vld_pct);
        in_data = beats[idx];
      end else begin
        in_vld  = $urandom_range(1);
        in_data = rand_beat();
      end
      start = poke_start && ($urandom_range(7) == 0);
      if (start) len = AW'($urandom_range(1, 20));
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_rdy = $urandom_range(1);
      endcase
      tick();
    end
    check("job_finished", (n_done != 0), 1);
    start  = 1'b0;
    in_vld = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    check("done_pulses", n_done, 1);
    check("busy_span", busy_cycles, done_cyc - start_cyc);
    check("beats_accepted", n_we, eff);
    check("words_drained", n_pop, 2 * eff);
    check("err_flag", err, err_exp);

    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== AW'(2 * i)) bad++;
    check("wr_addr_seq", bad, 0);
    check("rd_count", rd_q.size(), 2 * eff);
    bad = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== AW'(i)) bad++;
    check("rd_addr_seq", bad, 0);

    check("first_vld_latency", first_vld_cyc, last_beat_cyc + 3);
    check("done_after_last_word", done_cyc, last_pop_cyc + 1);
    if (rdy_mode == 0) check("throughput", last_pop_cyc - first_vld_cyc, 2 * eff - 1);

    if (chk_data) begin
      bad = 0;
      for (int i = 0; i < out_q.size() && i < 2 * eff; i++) begin
        exp_w = (i % 2 == 1) ? beats[i / 2][IW-1:OW] : beats[i / 2][OW-1:0];
        if (out_q[i] !== exp_w) begin
          if (bad == 0) check("out_word", out_q[i], exp_w);
          bad++;
        end
      end
      check("out_stream_errors", bad, 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int guard;
    clear_mon();
    exp_beats = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    len     = '0;
    in_vld  = 1'b1;
    in_data = rand_beat();
    out_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    zero_cycle("reset");

    // in_vld while IDLE must be ignored.
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      in_vld  = 1'b1;
      in_data = rand_beat();
      tick();
    end
    in_vld = 1'b0;
    check("idle_in_vld_writes", n_we, 0);
    check("idle_in_vld_busy", busy_cycles, 0);

    // Basic job: len = 2, beats back-to-back.
    run_job(2, 0, 1'b1, 1'b0, 100);

    // Backpressure: len = 4, out_rdy pattern 1,0,0,1.
    run_job(4, 1, 1'b1, 1'b0, 100);

    // Zero length.
    clear_mon();
    guard   = cyc;
    start   = 1'b1;
    len     = '0;
    in_vld  = 1'b1;
    out_rdy = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    in_vld = 1'b0;
    check("zero_len_busy_cycles", busy_cycles, 1);
    check("zero_len_done_cycle", done_cyc, guard + 1);
    check("zero_len_done_count", n_done, 1);
    check("zero_len_bram_access", n_we + n_re, 0);

    // start pulses during FILL/DRAIN are ignored.
    run_job(5, 2, 1'b1, 1'b1, 60);

    // Random jobs.
    for (int j = 0; j < 5; j++)
      run_job($urandom_range(1, 12), j % 3, 1'b1, 1'b0, 75);

    // Reset in the middle of DRAIN.
    clear_mon();
    exp_beats = 3;
    start     = 1'b1;
    len       = AW'(3);
    out_rdy   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && n_pop < 2; c++) begin
      in_vld  = 1'b1;
      in_data = rand_beat();
      tick();
    end
    check("mid_drain_reached", (n_pop >= 2), 1);
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
    err_exp = 1'b0;
    zero_cycle("rst_abort");
    clear_mon();
    out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_done", n_done, 0);
    check("abort_no_bram", n_we + n_re, 0);
    run_job(1, 0, 1'b1, 1'b0, 100);

    // Length check at len = 1500. With the check enabled, the job is clamped
    // to 1024 beats and err is set. Without it, err stays 0 and the stored
    // contents are undefined, so only counts, addresses and flags are checked.
`ifdef OUT_BRAM_CTRL_LEN_CHK_EN
    run_job(1500, 0, 1'b1, 1'b0, 90);
`else
    run_job(1500, 0, 1'b0, 1'b0, 90);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/out_bram_ctrl.md
OUT_BRAM_CTRL -- requirements
Module: out_bram_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 11, BRAM address width; DEPTH, default 2048, BRAM depth in 128-bit words; IN_DATA_WIDTH, default 256, write-beat width; OUT_DATA_WIDTH, default 128, read-word width.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse, begins a job; sampled only in IDLE
- len  in  ADDR_WIDTH  job length in 256-bit beats, sampled with start
- in_vld / in_rdy  in / out  1 / 1  result-beat handshake
- in_data  in  IN_DATA_WIDTH  result beat
- bram_we  out  1  BRAM write enable
- bram_wr_addr  out  ADDR_WIDTH  BRAM write address; always even
- bram_wr_data  out  IN_DATA_WIDTH  BRAM write data
- bram_re  out  1  BRAM read enable
- bram_rd_addr  out  ADDR_WIDTH  BRAM read address
- bram_rd_data  in  OUT_DATA_WIDTH  BRAM read data; 1-cycle latency; zero when re was low
- out_vld / out_rdy  out / in  1 / 1  drain-stream handshake
- out_data  out  OUT_DATA_WIDTH  drained 128-bit word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky length error (see Configuration)

Function
REQ-003 SHALL implement the FSM IDLE -> FILL -> DRAIN -> DONE -> IDLE.
REQ-004 IDLE: in_rdy=0, bram_we=0, bram_re=0. On start with len!=0, SHALL latch len, clear pointers, and go to FILL. On start with len==0, SHALL go to DONE directly.
REQ-005 FILL: in_rdy=1. Each cycle with in_vld&in_rdy, SHALL drive bram_we=1, bram_wr_addr=wptr, bram_wr_data=in_data in that same cycle (combinational), then advance wptr by 2.
REQ-006 FILL SHALL exit to DRAIN in the cycle after the len-th beat is accepted. in_rdy SHALL be 0 in that following cycle.
REQ-007 DRAIN SHALL read addresses 0..2*len-1 in ascending order, one per cycle with bram_re=1, whenever (reads in flight + words held) < 2.
REQ-008 Returned read data SHALL be captured into a 2-entry skid buffer. out_data SHALL present the head entry and out_vld SHALL be high while the buffer is non-empty.
REQ-009 While out_vld=1 and out_rdy=0, out_data SHALL be held stable. No word SHALL be lost, duplicated, or reordered.
REQ-010 Timing: first out_vld SHALL be 2 cycles after entering DRAIN. With out_rdy held high, the block SHALL sustain 1 word/cycle.
REQ-011 DRAIN SHALL exit to DONE in the cycle after the last (2*len-th) word handshakes.
REQ-012 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-013 start asserted outside IDLE SHALL be ignored. in_vld outside FILL SHALL be ignored (in_rdy=0).
REQ-014 Pointers SHALL be ADDR_WIDTH+1 bits wide. Beat/word counters SHALL compare against the latched len so that len=DEPTH/2 drains exactly DEPTH words with no wrap.

Reset
REQ-015 On rst_n=0 at a clock edge, SHALL go to IDLE and clear pointers, counters, and the skid buffer. All outputs SHALL read 0 (in_rdy, bram_we, bram_re, out_vld, out_data, busy, done, err, addresses, wr_data).
REQ-016 Reset mid-FILL or mid-DRAIN SHALL abort the job silently: no done pulse, and no further BRAM access until the next start.

Configuration
REQ-017 SHALL use the macro OUT_BRAM_CTRL_LEN_CHK_EN.
- Defined: start with len > DEPTH/2 SHALL set err=1 (sticky until reset) and clamp the latched len to DEPTH/2.
- Undefined: err SHALL be tied 0 and len SHALL be used as given; len > DEPTH/2 is caller error with undefined contents.

Verification
REQ-018 Basic job: start with len=2, 2 beats A,B back-to-back. Required:
- writes at addr 0 and 2;
- DRAIN reads addr 0..3;
- out stream A[127:0], A[255:128], B[127:0], B[255:128];
- one done pulse.
REQ-019 Backpressure: len=4 with out_rdy toggling 1,0,0,1 repeatedly. Required: 8 words delivered in order, out_data stable during every stall, bram_re never issued with 2 words pending.
REQ-020 Zero length: start with len=0. Required: busy high exactly 1 cycle, done pulse 1 cycle after start, bram_we and bram_re never asserted.
REQ-021 Reset mid-DRAIN: len=3, rst_n low after 2 words drained. Required: all outputs 0 the next cycle, no done pulse, new start with len=1 completes normally.
REQ-022 Length check (macro defined): start with len=1500 at DEPTH=2048. Required: err=1, 1024 beats accepted, 2048 words drained. With macro undefined: err stays 0.
REQ-023 Ignored inputs: start asserted during FILL and in_vld asserted in IDLE. Required: no state change and no BRAM write.
